mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
E-stage multiply/divide unit that is the responder on the start/busy handshake consumed by the pipeline hazard control. On a start pulse it runs a fixed-latency MULT/MULTU/DIV/DIVU and holds busy for the operation length. It owns the HI/LO registers and exposes them for MFHI/MFLO. It accepts direct MTHI/MTLO writes.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle launch strobe from E stage; valid only with a mult/div op
md_op  input  3  operation select (package encoding)
hilo_we  input  1  MTHI/MTLO write strobe; md_op selects the target
rs_val  input  32  operand A, forwarded E-stage value
rt_val  input  32  operand B, forwarded E-stage value
busy  output  1  operation in progress
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
Reset and timing
- Reset: busy=0, hi=0, lo=0, cnt=0, pending results=0. Reset dominates all other inputs, including mid-operation; an in-flight result is discarded.
- States: IDLE (cnt==0) and RUN (cnt!=0). busy is registered and equals (cnt!=0).

Launch and completion
- IDLE with start=1 at edge t:
  - Compute the result combinationally from rs_val/rt_val and latch it into pend_hi/pend_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES.
  - busy=1 from t+1.
- RUN: cnt decrements each edge. On the edge where cnt==1: hi/lo <= pend_hi/pend_lo, cnt becomes 0, and busy falls at that same edge. For N cycles of latency, busy is high for exactly N cycles and new hi/lo are visible in the first cycle busy=0.

Arithmetic
- MULT: signed 32x32 multiply to a 64-bit product; hi=[63:32], lo=[31:0].
- MULTU: unsigned 32x32 multiply, same split.
- DIV: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
- DIVU: unsigned divide, same hi/lo assignment.
- Divisor == 0: the op still runs the full DIV_CYCLES with busy high, but hi/lo are left unchanged at completion.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.

MTHI/MTLO
- hilo_we=1 in IDLE: hi or lo <= rs_val at the next edge. busy is not asserted.

Illegal or overlapping requests
- start or hilo_we while busy=1: ignored. Hazard control stalls D and these requests must not reach the unit; an assertion flags any occurrence.
- start and hilo_we in the same cycle: start wins and hilo_we is ignored; also flagged by assertion.
- start with md_op not a mult/div code: ignored.
- hi/lo outputs hold their old values throughout RUN. MF reads during busy are the stall logic's concern.

Decomposition:
- Shared package holds:
  - md_op encoding: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5.
  - Helper function is_md_start(op), true for codes 0-3.
  - Default latency constants.
- One natural sub-module: mdu_arith, purely combinational. It maps op/a/b to {res_hi, res_lo, div_by_zero}. This keeps the sequencing FSM in mult_div_unit small and separately verifiable.

Test Plan:
- MULT rs=3, rt=4 -> busy high exactly 5 cycles; then hi=0x00000000, lo=0x0000000C.
- MULT rs=0xFFFFFFFF, rt=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=2 -> lo=3, hi=1.
- MTHI 0x12345678, then DIVU rs=7, rt=0 -> busy 10 cycles; hi still 0x12345678, lo unchanged.
- MULT launched, second start plus hilo_we pulsed at busy cycle 2 -> both ignored; completion result is from the first op only.
- Reset asserted in busy cycle 3 of a DIV -> next cycle busy=0, hi=lo=0; no later update occurs.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// ----------------------------------------------------------------------------
// mult_div_unit_pkg
// Shared definitions for the E-stage multiply/divide unit.
//   md_op_e       : operation select encoding carried on md_op
//   md_state_e    : sequencing FSM states (IDLE when no count, RUN otherwise)
//   DEF_*_CYCLES  : default busy latencies for multiply and divide
//   is_md_start() : true for the four codes that launch an arithmetic op
// ----------------------------------------------------------------------------
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    function automatic logic is_md_start(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// ----------------------------------------------------------------------------
// mult_div_unit_if
// Start/busy handshake plus HI/LO read-back between the E stage (master)
// and the multiply/divide unit (slave).
//   start    : one-cycle launch strobe
//   md_op    : operation select / MTHI-MTLO target
//   hilo_we  : MTHI/MTLO write strobe
//   rs_val   : operand A (also MTHI/MTLO data)
//   rt_val   : operand B
//   busy     : operation in progress
//   hi, lo   : architectural HI/LO registers
// ----------------------------------------------------------------------------
interface mult_div_unit_if;
    import mult_div_unit_pkg::*;

    logic        start;
    md_op_e      md_op;
    logic        hilo_we;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, hilo_we, rs_val, rt_val,
        input  busy, hi, lo
    );

    modport slave (
        input  start, md_op, hilo_we, rs_val, rt_val,
        output busy, hi, lo
    );

endinterface

// File: rtl/mdu_arith.sv
// ----------------------------------------------------------------------------
// mdu_arith
// Purely combinational arithmetic core of the multiply/divide unit.
//   op          : in  md_op_e   operation select
//   a, b        : in  [31:0]    operands (dividend/divisor for divides)
//   res_hi      : out [31:0]    product high word / remainder
//   res_lo      : out [31:0]    product low word / quotient
//   div_by_zero : out           divide op with b == 0 (result must be dropped)
// ----------------------------------------------------------------------------
module mdu_arith
    import mult_div_unit_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        b_zero;
    logic [31:0] safe_b;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // A zero divisor is replaced by 1 so the divider never sees x/0; the
    // result is discarded downstream via div_by_zero.
    assign b_zero = (b == 32'd0);
    assign safe_b = b_zero ? 32'd1 : b;
    assign q_u    = a / safe_b;
    assign r_u    = a % safe_b;

    // Signed divide on magnitudes; this also makes 0x80000000 / -1 wrap to
    // 0x80000000 without relying on the host's signed-overflow behaviour.
    assign abs_a  = a[31] ? (32'd0 - a) : a;
    assign abs_b  = b_zero ? 32'd1 : (b[31] ? (32'd0 - b) : b);
    assign q_mag  = abs_a / abs_b;
    assign r_mag  = abs_a % abs_b;

    always_comb begin
        res_hi      = 32'd0;
        res_lo      = 32'd0;
        div_by_zero = 1'b0;
        case (op)
            MD_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MD_DIV: begin
                res_lo      = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
                res_hi      = a[31] ? (32'd0 - r_mag) : r_mag;
                div_by_zero = b_zero;
            end
            MD_DIVU: begin
                res_lo      = q_u;
                res_hi      = r_u;
                div_by_zero = b_zero;
            end
            default: begin
                res_hi      = 32'd0;
                res_lo      = 32'd0;
                div_by_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// ----------------------------------------------------------------------------
// mult_div_unit
// E-stage multiply/divide unit. Launches a fixed-latency MULT/MULTU/DIV/DIVU
// on start, holds busy for the op length, then commits HI/LO. Accepts
// MTHI/MTLO writes while idle.
//   clk   : in   system clock
//   reset : in   synchronous active-high reset (discards any in-flight op)
//   bus   : mult_div_unit_if.slave (start, md_op, hilo_we, rs_val, rt_val,
//           busy, hi, lo)
// ----------------------------------------------------------------------------
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)
(
    input  logic          clk,
    input  logic          reset,
    mult_div_unit_if.slave bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e          state_reg,   state_next;
    logic [CNT_W-1:0]   cnt_reg,     cnt_next;
    logic               busy_reg,    busy_next;
    logic [31:0]        hi_reg,      hi_next;
    logic [31:0]        lo_reg,      lo_next;
    logic [31:0]        pend_hi_reg, pend_hi_next;
    logic [31:0]        pend_lo_reg, pend_lo_next;
    logic               pend_dz_reg, pend_dz_next;

    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               div_by_zero;
    logic               is_div;

    mdu_arith u_arith (
        .op          (bus.md_op),
        .a           (bus.rs_val),
        .b           (bus.rt_val),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .div_by_zero (div_by_zero)
    );

    assign is_div = (bus.md_op == MD_DIV) || (bus.md_op == MD_DIVU);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        pend_hi_next = pend_hi_reg;
        pend_lo_next = pend_lo_reg;
        pend_dz_next = pend_dz_reg;

        case (state_reg)
            ST_IDLE: begin
                // start takes priority over hilo_we even when its op code
                // is not an arithmetic one.
                if (bus.start) begin
                    if (is_md_start(bus.md_op)) begin
                        pend_hi_next = res_hi;
                        pend_lo_next = res_lo;
                        pend_dz_next = div_by_zero;
                        cnt_next     = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    end
                end else if (bus.hilo_we) begin
                    if (bus.md_op == MD_MTHI) begin
                        hi_next = bus.rs_val;
                    end else if (bus.md_op == MD_MTLO) begin
                        lo_next = bus.rs_val;
                    end
                end
            end
            ST_RUN: begin
                // Requests arriving here are ignored; hazard control should
                // never let them through.
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1) && !pend_dz_reg) begin
                    hi_next = pend_hi_reg;
                    lo_next = pend_lo_reg;
                end
            end
            default: begin
                cnt_next = '0;
            end
        endcase

        // busy and state are both just "count still running", registered.
        busy_next  = (cnt_next != '0);
        state_next = busy_next ? ST_RUN : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
            pend_hi_reg <= 32'd0;
            pend_lo_reg <= 32'd0;
            pend_dz_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            busy_reg    <= busy_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            pend_hi_reg <= pend_hi_next;
            pend_lo_reg <= pend_lo_next;
            pend_dz_reg <= pend_dz_next;
        end
    end

    assign bus.busy = busy_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;

    // Protocol checks: these requests are dropped by the logic above, but
    // their appearance means the stall logic upstream is wrong.
    a_no_req_while_busy: assert property (
        @(posedge clk) disable iff (reset) busy_reg |-> !(bus.start || bus.hilo_we)
    ) else $warning("mult_div_unit: request while busy was dropped");

    a_no_start_with_we: assert property (
        @(posedge clk) disable iff (reset) !(bus.start && bus.hilo_we)
    ) else $warning("mult_div_unit: start and hilo_we together, hilo_we dropped");

endmodule

// File: tb/tb_mult_div_unit.sv
// ----------------------------------------------------------------------------
// tb_mult_div_unit
// Directed self-checking bench for mult_div_unit (MULT_CYCLES=5,
// DIV_CYCLES=10). Inputs are driven and outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mult_div_unit_if md_if();

    mult_div_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (md_if.slave)
    );

    int assertions_evaluated = 0;
    int failures             = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertions_evaluated++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Launch one op at the current falling edge and count busy cycles
    // (bounded); returns at the falling edge of the first non-busy cycle.
    task automatic run_op(input string tag, input md_op_e op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_cycles);
        int n;
        md_if.start  = 1'b1;
        md_if.md_op  = op;
        md_if.rs_val = a;
        md_if.rt_val = b;
        @(negedge clk);
        md_if.start  = 1'b0;
        n = 0;
        while (md_if.busy === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        check_eq({tag, " busy_cycles"}, 32'(n), 32'(exp_cycles));
    endtask

    task automatic write_hilo(input md_op_e op, input logic [31:0] val);
        md_if.hilo_we = 1'b1;
        md_if.md_op   = op;
        md_if.rs_val  = val;
        @(negedge clk);
        md_if.hilo_we = 1'b0;
    endtask

    initial begin
        int n;

        reset         = 1'b1;
        md_if.start   = 1'b0;
        md_if.hilo_we = 1'b0;
        md_if.md_op   = MD_MULT;
        md_if.rs_val  = 32'd0;
        md_if.rt_val  = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("reset busy", 32'(md_if.busy), 32'd0);
        check_eq("reset hi", md_if.hi, 32'd0);
        check_eq("reset lo", md_if.lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("mult 3*4", MD_MULT, 32'd3, 32'd4, 5);
        check_eq("mult 3*4 hi", md_if.hi, 32'h0000_0000);
        check_eq("mult 3*4 lo", md_if.lo, 32'h0000_000C);

        run_op("mult -1*2", MD_MULT, 32'hFFFF_FFFF, 32'd2, 5);
        check_eq("mult -1*2 hi", md_if.hi, 32'hFFFF_FFFF);
        check_eq("mult -1*2 lo", md_if.lo, 32'hFFFF_FFFE);

        run_op("multu ffffffff*2", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5);
        check_eq("multu hi", md_if.hi, 32'h0000_0001);
        check_eq("multu lo", md_if.lo, 32'hFFFF_FFFE);

        run_op("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10);
        check_eq("div -7/2 hi", md_if.hi, 32'hFFFF_FFFF);
        check_eq("div -7/2 lo", md_if.lo, 32'hFFFF_FFFD);

        run_op("divu 7/2", MD_DIVU, 32'd7, 32'd2, 10);
        check_eq("divu 7/2 hi", md_if.hi, 32'd1);
        check_eq("divu 7/2 lo", md_if.lo, 32'd3);

        write_hilo(MD_MTHI, 32'h1234_5678);
        check_eq("mthi busy", 32'(md_if.busy), 32'd0);
        check_eq("mthi hi", md_if.hi, 32'h1234_5678);
        check_eq("mthi lo kept", md_if.lo, 32'd3);

        run_op("divu 7/0", MD_DIVU, 32'd7, 32'd0, 10);
        check_eq("divu 7/0 hi kept", md_if.hi, 32'h1234_5678);
        check_eq("divu 7/0 lo kept", md_if.lo, 32'd3);

        write_hilo(MD_MTLO, 32'hCAFE_F00D);
        check_eq("mtlo lo", md_if.lo, 32'hCAFE_F00D);
        check_eq("mtlo hi kept", md_if.hi, 32'h1234_5678);

        run_op("div min/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        check_eq("div min/-1 hi", md_if.hi, 32'h0000_0000);
        check_eq("div min/-1 lo", md_if.lo, 32'h8000_0000);

        // start with a non-arithmetic code must not launch anything
        md_if.start  = 1'b1;
        md_if.md_op  = MD_MTHI;
        md_if.rs_val = 32'hDEAD_BEEF;
        @(negedge clk);
        md_if.start  = 1'b0;
        check_eq("start mthi-code busy", 32'(md_if.busy), 32'd0);
        check_eq("start mthi-code hi", md_if.hi, 32'h0000_0000);
        @(negedge clk);
        check_eq("start mthi-code busy later", 32'(md_if.busy), 32'd0);

        // MULT 5*6 with illegal start+hilo_we in busy cycle 2 and MTLO in cycle 3
        md_if.start  = 1'b1;
        md_if.md_op  = MD_MULT;
        md_if.rs_val = 32'd5;
        md_if.rt_val = 32'd6;
        @(negedge clk);
        md_if.start = 1'b0;
        n = 0;
        while (md_if.busy === 1'b1 && n < 64) begin
            n++;
            case (n)
                2: begin
                    md_if.start   = 1'b1;
                    md_if.hilo_we = 1'b1;
                    md_if.md_op   = MD_MULTU;
                    md_if.rs_val  = 32'd7;
                    md_if.rt_val  = 32'd7;
                end
                3: begin
                    md_if.start   = 1'b0;
                    md_if.hilo_we = 1'b1;
                    md_if.md_op   = MD_MTLO;
                    md_if.rs_val  = 32'h0000_0BAD;
                end
                4: begin
                    md_if.hilo_we = 1'b0;
                end
                default: ;
            endcase
            @(negedge clk);
        end
        md_if.start   = 1'b0;
        md_if.hilo_we = 1'b0;
        check_eq("overlap busy_cycles", 32'(n), 32'd5);
        check_eq("overlap hi", md_if.hi, 32'h0000_0000);
        check_eq("overlap lo", md_if.lo, 32'h0000_001E);
        @(negedge clk);
        check_eq("overlap no relaunch", 32'(md_if.busy), 32'd0);

        // Reset in busy cycle 3 of DIV 100/7
        md_if.start  = 1'b1;
        md_if.md_op  = MD_DIV;
        md_if.rs_val = 32'd100;
        md_if.rt_val = 32'd7;
        @(negedge clk);
        md_if.start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst div busy cycle3", 32'(md_if.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst div busy", 32'(md_if.busy), 32'd0);
        check_eq("rst div hi", md_if.hi, 32'd0);
        check_eq("rst div lo", md_if.lo, 32'd0);
        repeat (15) @(negedge clk);
        check_eq("rst div busy later", 32'(md_if.busy), 32'd0);
        check_eq("rst div hi later", md_if.hi, 32'd0);
        check_eq("rst div lo later", md_if.lo, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions_evaluated, failures);
        $finish;
    end

endmodule
